alu_operand_loader: RTL and testbench
=====================================

// Module: alu_operand_loader
// PURPOSE
//   Upstream sequencer for the 8-bit alu. Loads A, B and OP one after another from board
//   switches, one debounced button press each, and drives them to the alu as registered signals.
//   Captures the alu result, carry and zero one cycle after OP is loaded and holds them for display.
// PARAMETERS
//   DATA_W     8  operand/result width (alu a, b, rdo)
//   OP_W       6  opcode width (alu op)
//   DB_CYCLES  4  consecutive stable cycles for a synchronized button change (>=1)
// PORTS
//   clk         in   1       system clock, all logic on rising edge
//   reset       in   1       synchronous, active-high reset
//   sw          in   DATA_W  switch value; OP loads from sw[OP_W-1:0]
//   btn         in   1       raw asynchronous push-button
//   alu_rdo     in   DATA_W  alu result
//   alu_carry   in   1       alu carry (result bit DATA_W)
//   alu_zero    in   1       alu zero flag
//   a_out       out  DATA_W  registered operand A to alu
//   b_out       out  DATA_W  registered operand B to alu
//   op_out      out  OP_W    registered opcode to alu
//   res_out     out  DATA_W  captured result
//   carry_out   out  1       captured carry
//   zero_out    out  1       captured zero
//   res_valid   out  1       high while state = SHOW
//   illegal_op  out  1       captured: op_out was not a legal code
//   state_out   out  3       current state encoding (for LEDs)
// BEHAVIOUR
//   Reset (any cycle, including mid-sequence): all outputs 0, state LOAD_A, sync/debounce regs 0, cnt 0.
//   Button path:
//   - btn feeds a 2-FF synchronizer -> btn_s.
//   - If btn_s != btn_db, cnt increments; on reaching DB_CYCLES-1, btn_db <= btn_s and cnt <= 0.
//   - If btn_s == btn_db, cnt <= 0.
//   - press is a 1-cycle registered pulse on each 0->1 of btn_db. No pulse on release.
//   - A button held through reset gives exactly one press after reset deasserts.
//   - Glitch shorter than DB_CYCLES cycles: no press.
//   States: LOAD_A=0, LOAD_B=1, LOAD_OP=2, CAPTURE=3, SHOW=4. Advance only on press, except CAPTURE.
//   - LOAD_A  + press: a_out <= sw; -> LOAD_B.
//   - LOAD_B  + press: b_out <= sw; -> LOAD_OP.
//   - LOAD_OP + press: op_out <= sw[OP_W-1:0]; -> CAPTURE.
//   - CAPTURE, unconditional, 1 cycle:
//     - legal op: res_out <= alu_rdo; carry_out <= alu_carry; zero_out <= alu_zero; illegal_op <= 0.
//     - illegal op: res_out <= 0, carry_out <= 0, zero_out <= 0, illegal_op <= 1.
//     - -> SHOW.
//   - SHOW: res_valid = 1; captured values hold. On press -> LOAD_A; res_valid, illegal_op clear.
//     a_out/b_out/op_out hold until overwritten.
//   Legal OP codes: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 000011 sra,
//     000010 srl, 100111 nor. Any other value is illegal.
//   Latency: press in cycle N (state LOAD_OP) -> op_out valid N+1 -> res_valid=1 from N+2.
//   press is ignored in CAPTURE, but a press cannot arrive there because the debounce spacing
//   between presses is >= DB_CYCLES+1 cycles.
//   sw is sampled only on the press cycle; changes at other times have no effect.
//   The alu is combinational: the CAPTURE cycle alone covers its settling; no other wait.
// TESTING
//   1. Reset held, then released: every output 0, state_out=0; 20 idle cycles -> no state change.
//   2. Add: A=0x0F, B=0x01, OP=100000 via 3 clean presses -> res_out=0x10, carry 0, zero 0, res_valid=1.
//   3. Carry/zero: A=0xFF, B=0x01, add -> res_out=0x00, carry_out=1, zero_out=1.
//   4. Sub, then shift:
//      - A=0x05, B=0x05, OP=100010 -> res_out=0x00, zero_out=1.
//      - Next press returns to LOAD_A. A=0x80, any B, OP=000011 -> res_out=0xC0.
//   5. Illegal OP=111111 -> illegal_op=1, res_out=0, carry_out=0, zero_out=0, res_valid=1.
//   6. Bounce/reset:
//      - btn high 2 cycles (DB_CYCLES=4) -> no press.
//      - Reset asserted in LOAD_OP -> state LOAD_A, a_out=b_out=0 next cycle.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Sequencer that loads A, B and OP from switches on debounced button presses,
// drives them to the alu and captures the alu result for display.
module alu_operand_loader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OP_W      = 6,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn,
    input  logic [DATA_W-1:0] alu_rdo,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [OP_W-1:0]   op_out,
    output logic [DATA_W-1:0] res_out,
    output logic              carry_out,
    output logic              zero_out,
    output logic              res_valid,
    output logic              illegal_op,
    output logic [2:0]        state_out
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [2:0] S_LOAD_A  = 3'd0;
    localparam logic [2:0] S_LOAD_B  = 3'd1;
    localparam logic [2:0] S_LOAD_OP = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_SHOW    = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_db;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_db_flip;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_res;
    logic              r_carry;
    logic              r_zero;
    logic              r_valid;
    logic              r_illegal;

    logic [2:0]        w_state_nxt;
    logic [DATA_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_b_nxt;
    logic [OP_W-1:0]   w_op_nxt;
    logic [DATA_W-1:0] w_res_nxt;
    logic              w_carry_nxt;
    logic              w_zero_nxt;
    logic              w_valid_nxt;
    logic              w_illegal_nxt;

    function automatic logic f_legal(input logic [OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        if (op == OP_W'(6'b100000) || op == OP_W'(6'b100010) ||
            op == OP_W'(6'b100100) || op == OP_W'(6'b100101) ||
            op == OP_W'(6'b100110) || op == OP_W'(6'b000011) ||
            op == OP_W'(6'b000010) || op == OP_W'(6'b100111))
            legal = 1'b1;
        return legal;
    endfunction

    // Debounced level flips after DB_CYCLES consecutive cycles of disagreement
    assign w_db_flip = (r_sync2 != r_btn_db) && (r_cnt == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_btn_db <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_press <= w_db_flip && r_sync2;
            if (r_sync2 == r_btn_db) begin
                r_cnt <= '0;
            end else if (w_db_flip) begin
                r_btn_db <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_LOAD_A;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_op      <= w_op_nxt;
            r_res     <= w_res_nxt;
            r_carry   <= w_carry_nxt;
            r_zero    <= w_zero_nxt;
            r_valid   <= w_valid_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Next state and next register values; alu settles during CAPTURE
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_op_nxt      = r_op;
        w_res_nxt     = r_res;
        w_carry_nxt   = r_carry;
        w_zero_nxt    = r_zero;
        w_valid_nxt   = r_valid;
        w_illegal_nxt = r_illegal;
        case (r_state)
            S_LOAD_A: begin
                if (r_press) begin
                    w_a_nxt     = sw;
                    w_state_nxt = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (r_press) begin
                    w_b_nxt     = sw;
                    w_state_nxt = S_LOAD_OP;
                end
            end
            S_LOAD_OP: begin
                if (r_press) begin
                    w_op_nxt    = sw[OP_W-1:0];
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (f_legal(r_op)) begin
                    w_res_nxt     = alu_rdo;
                    w_carry_nxt   = alu_carry;
                    w_zero_nxt    = alu_zero;
                    w_illegal_nxt = 1'b0;
                end else begin
                    w_res_nxt     = '0;
                    w_carry_nxt   = 1'b0;
                    w_zero_nxt    = 1'b0;
                    w_illegal_nxt = 1'b1;
                end
                w_valid_nxt = 1'b1;
                w_state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (r_press) begin
                    w_valid_nxt   = 1'b0;
                    w_illegal_nxt = 1'b0;
                    w_state_nxt   = S_LOAD_A;
                end
            end
            default: begin
                w_state_nxt = S_LOAD_A;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign a_out      = r_a;
    assign b_out      = r_b;
    assign op_out     = r_op;
    assign res_out    = r_res;
    assign carry_out  = r_carry;
    assign zero_out   = r_zero;
    assign res_valid  = r_valid;
    assign illegal_op = r_illegal;
    assign state_out  = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a small combinational alu attached.
module tb_alu_operand_loader;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic       btn;
    logic [7:0] alu_rdo;
    logic       alu_carry;
    logic       alu_zero;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [5:0] op_out;
    logic [7:0] res_out;
    logic       carry_out;
    logic       zero_out;
    logic       res_valid;
    logic       illegal_op;
    logic [2:0] state_out;

    int n_pass;
    int n_total;

    alu_operand_loader #(.DATA_W(8), .OP_W(6), .DB_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .btn        (btn),
        .alu_rdo    (alu_rdo),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .a_out      (a_out),
        .b_out      (b_out),
        .op_out     (op_out),
        .res_out    (res_out),
        .carry_out  (carry_out),
        .zero_out   (zero_out),
        .res_valid  (res_valid),
        .illegal_op (illegal_op),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment alu driven by the loader outputs
    logic [8:0] alu_full;
    always_comb begin
        case (op_out)
            6'b100000: alu_full = {1'b0, a_out} + {1'b0, b_out};
            6'b100010: alu_full = {1'b0, a_out} - {1'b0, b_out};
            6'b100100: alu_full = {1'b0, a_out & b_out};
            6'b100101: alu_full = {1'b0, a_out | b_out};
            6'b100110: alu_full = {1'b0, a_out ^ b_out};
            6'b100111: alu_full = {1'b0, ~(a_out | b_out)};
            6'b000011: alu_full = {1'b0, a_out[7], a_out[7:1]};
            6'b000010: alu_full = {2'b00, a_out[7:1]};
            default:   alu_full = 9'h0AA;
        endcase
    end
    assign alu_rdo   = alu_full[7:0];
    assign alu_carry = alu_full[8];
    assign alu_zero  = (alu_full[7:0] == 8'h00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic press(input logic [7:0] v);
        sw  = v;
        btn = 1'b1;
        repeat (8) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp_res,
                          input logic exp_c, input logic exp_z, input logic exp_ill);
        press(a);
        chk({tag, "_state_b"}, 32'(state_out), 32'd1);
        chk({tag, "_a_out"}, 32'(a_out), 32'(a));
        press(b);
        chk({tag, "_b_out"}, 32'(b_out), 32'(b));
        press(op);
        chk({tag, "_op_out"}, 32'(op_out), 32'(op[5:0]));
        chk({tag, "_state_show"}, 32'(state_out), 32'd4);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_res"}, 32'(res_out), 32'(exp_res));
        chk({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
        chk({tag, "_zero"}, 32'(zero_out), 32'(exp_z));
        chk({tag, "_illegal"}, 32'(illegal_op), 32'(exp_ill));
        sw = 8'h5A;
        repeat (5) @(negedge clk);
        chk({tag, "_hold_res"}, 32'(res_out), 32'(exp_res));
        press(8'h00);
        chk({tag, "_back_to_a"}, 32'(state_out), 32'd0);
        chk({tag, "_valid_clr"}, 32'(res_valid), 32'd0);
        chk({tag, "_illegal_clr"}, 32'(illegal_op), 32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        btn     = 1'b0;
        sw      = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_a", 32'(a_out), 32'd0);
        chk("rst_b", 32'(b_out), 32'd0);
        chk("rst_op", 32'(op_out), 32'd0);
        chk("rst_res", 32'(res_out), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_zero", 32'(zero_out), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        sw = 8'hFF;
        repeat (20) @(negedge clk);
        chk("idle_state", 32'(state_out), 32'd0);
        chk("idle_a", 32'(a_out), 32'd0);

        run_op("add",   8'h0F, 8'h01, 8'h20, 8'h10, 1'b0, 1'b0, 1'b0);
        run_op("addcz", 8'hFF, 8'h01, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op("sub",   8'h05, 8'h05, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op("sra",   8'h80, 8'h33, 8'h03, 8'hC0, 1'b0, 1'b0, 1'b0);
        run_op("srl",   8'h80, 8'h33, 8'h02, 8'h40, 1'b0, 1'b0, 1'b0);
        run_op("illeg", 8'h12, 8'h34, 8'h3F, 8'h00, 1'b0, 1'b0, 1'b1);

        // Short glitch must not advance the state
        sw  = 8'h77;
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_state", 32'(state_out), 32'd0);
        chk("glitch_a", 32'(a_out), 32'h12);

        press(8'h11);
        press(8'h22);
        chk("pre_rst_state", 32'(state_out), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_state", 32'(state_out), 32'd0);
        chk("midrst_a", 32'(a_out), 32'd0);
        chk("midrst_b", 32'(b_out), 32'd0);
        chk("midrst_op", 32'(op_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Button held through reset yields exactly one press
        sw    = 8'h9C;
        btn   = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_state", 32'(state_out), 32'd1);
        chk("held_a", 32'(a_out), 32'h9C);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_release_state", 32'(state_out), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
